// File: rtl/edge_pkg.sv
// Shared types and constants for the 3x3 window fetch front end.
// Holds the fetch FSM encoding and the pixel width used by the line buffers.
package edge_pkg;

  localparam int unsigned PIX_W          = 8;
  localparam int unsigned DEF_IMG_WIDTH  = 16;
  localparam int unsigned DEF_IMG_HEIGHT = 16;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    ACCEPT,
    START,
    WAIT_DONE,
    WAIT_CLEAR
  } fetch_state_t;

endpackage

// File: rtl/window_fetch_if.sv
// Pixel stream, window and detector handshake bundle for window_fetch.
// The slave modport is the fetch block's view; master is the feeder/detector side.
interface window_fetch_if
  import edge_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT
) ();

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

  logic             i_pix_valid;
  pix_t             i_pix_data;
  logic             o_pix_ready;
  pix_t             o_P0;
  pix_t             o_P1;
  pix_t             o_P2;
  pix_t             o_P3;
  pix_t             o_P4;
  pix_t             o_P5;
  pix_t             o_P6;
  pix_t             o_P7;
  pix_t             o_P8;
  logic             o_gradient_start;
  logic             i_gradient_done;
  logic [ROW_W-1:0] o_win_row;
  logic [COL_W-1:0] o_win_col;
  logic             o_frame_done;

  modport slave (
    input  i_pix_valid, i_pix_data, i_gradient_done,
    output o_pix_ready, o_P0, o_P1, o_P2, o_P3, o_P4, o_P5, o_P6, o_P7, o_P8,
    output o_gradient_start, o_win_row, o_win_col, o_frame_done
  );

  modport master (
    output i_pix_valid, i_pix_data, i_gradient_done,
    input  o_pix_ready, o_P0, o_P1, o_P2, o_P3, o_P4, o_P5, o_P6, o_P7, o_P8,
    input  o_gradient_start, o_win_row, o_win_col, o_frame_done
  );

endinterface

// File: rtl/line_buffer.sv
// One image line of pixels: combinational read at i_idx, write on i_we at the same index.
// A read and a write to the same index in one cycle returns the old value.
module line_buffer
  import edge_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_IMG_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  pix_t                     i_wdata,
  output pix_t                     o_rdata
);

  pix_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/window_fetch.sv
// Raster pixel stream to 3x3 window feeder for the edge detector.
// Presents one window per interior pixel and stalls the stream until the detector finishes.
module window_fetch
  import edge_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input logic          clk,
  input logic          rst,
  window_fetch_if.slave bus
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

  fetch_state_t     r_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  pix_t             r_win [9];
  logic             r_start;
  logic             r_frame_done;
  logic             r_last;
  logic [ROW_W-1:0] r_win_row;
  logic [COL_W-1:0] r_win_col;

  logic w_accept;
  logic w_col_last;
  logic w_row_last;
  logic w_is_win;
  pix_t w_lb0_rd;
  pix_t w_lb1_rd;

  assign w_accept   = bus.i_pix_valid && (r_state == ACCEPT);
  assign w_col_last = (r_col == COL_W'(IMG_WIDTH - 1));
  assign w_row_last = (r_row == ROW_W'(IMG_HEIGHT - 1));
  assign w_is_win   = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

  // lb0 holds line r-1, lb1 holds line r-2; both advance one line on each accept
  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_accept),
    .i_idx   (r_col),
    .i_wdata (bus.i_pix_data),
    .o_rdata (w_lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_accept),
    .i_idx   (r_col),
    .i_wdata (w_lb0_rd),
    .o_rdata (w_lb1_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ACCEPT;
      r_col        <= '0;
      r_row        <= '0;
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
      r_last       <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
      for (int i = 0; i < 9; i++) begin
        r_win[i] <= '0;
      end
    end else begin
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;

      if (w_accept) begin
        r_win[0] <= r_win[1];
        r_win[1] <= r_win[2];
        r_win[2] <= w_lb1_rd;
        r_win[3] <= r_win[4];
        r_win[4] <= r_win[5];
        r_win[5] <= w_lb0_rd;
        r_win[6] <= r_win[7];
        r_win[7] <= r_win[8];
        r_win[8] <= bus.i_pix_data;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end

      case (r_state)
        ACCEPT: begin
          if (w_accept && w_is_win) begin
            r_win_row <= r_row - ROW_W'(1);
            r_win_col <= r_col - COL_W'(1);
            r_last    <= w_row_last && w_col_last;
            r_start   <= 1'b1;
            r_state   <= START;
          end
        end
        START: r_state <= WAIT_DONE;
        WAIT_DONE: begin
          if (bus.i_gradient_done) r_state <= WAIT_CLEAR;
        end
        // Wait for done to drop so a multi-cycle done counts as one job
        WAIT_CLEAR: begin
          if (!bus.i_gradient_done) begin
            r_state <= ACCEPT;
            if (r_last) begin
              r_frame_done <= 1'b1;
              r_last       <= 1'b0;
            end
          end
        end
        default: r_state <= ACCEPT;
      endcase
    end
  end

  assign bus.o_pix_ready      = (r_state == ACCEPT);
  assign bus.o_gradient_start = r_start;
  assign bus.o_frame_done     = r_frame_done;
  assign bus.o_win_row        = r_win_row;
  assign bus.o_win_col        = r_win_col;
  assign bus.o_P0             = r_win[0];
  assign bus.o_P1             = r_win[1];
  assign bus.o_P2             = r_win[2];
  assign bus.o_P3             = r_win[3];
  assign bus.o_P4             = r_win[4];
  assign bus.o_P5             = r_win[5];
  assign bus.o_P6             = r_win[6];
  assign bus.o_P7             = r_win[7];
  assign bus.o_P8             = r_win[8];

endmodule

// File: tb/tb_window_fetch.sv
// Scoreboard bench for window_fetch on a 4x4 image: an image-array model predicts each
// window; a monitor pops and compares on every start pulse and checks stalls between.
module tb_window_fetch;
  import edge_pkg::*;

  localparam int unsigned W = 4;
  localparam int unsigned H = 4;

  typedef struct {
    logic [71:0] win;
    int          row;
    int          col;
    bit          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  window_fetch_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

  window_fetch #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t held;
  exp_t mon_e;
  bit   job_active = 0;
  bit   seen_done  = 0;
  bit   mon_en     = 0;
  bit   det_en     = 1;
  logic done_q     = 1'b0;
  int   n_start = 0, n_exp_start = 0, n_fd = 0, n_exp_fd = 0;
  int   dmin = 3, dmax = 3, lmin = 2, lmax = 2;

  logic [7:0] img [H][W];
  int         mrow = 0, mcol = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic give_up(input string what);
    total++;
    bad++;
    $display("FAIL %s: timed out", what);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  function automatic logic [71:0] cur_win();
    return {bus.o_P0, bus.o_P1, bus.o_P2, bus.o_P3, bus.o_P4,
            bus.o_P5, bus.o_P6, bus.o_P7, bus.o_P8};
  endfunction

  // Reference: store the pixel into the image, and emit a window for any interior position
  task automatic model_accept(input logic [7:0] p);
    exp_t e;
    img[mrow][mcol] = p;
    if (mrow >= 2 && mcol >= 2) begin
      e.win  = {img[mrow-2][mcol-2], img[mrow-2][mcol-1], img[mrow-2][mcol],
                img[mrow-1][mcol-2], img[mrow-1][mcol-1], img[mrow-1][mcol],
                img[mrow][mcol-2],   img[mrow][mcol-1],   img[mrow][mcol]};
      e.row  = mrow - 1;
      e.col  = mcol - 1;
      e.last = (mrow == int'(H) - 1) && (mcol == int'(W) - 1);
      q.push_back(e);
      n_exp_start++;
      if (e.last) n_exp_fd++;
    end
    mcol++;
    if (mcol == int'(W)) begin
      mcol = 0;
      mrow++;
      if (mrow == int'(H)) mrow = 0;
    end
  endtask

  always @(posedge clk) done_q <= bus.i_gradient_done;

  // Monitor: compare on every start, then check the stall until ready returns
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (bus.o_frame_done) n_fd++;
      if (bus.o_gradient_start) begin
        n_start++;
        check("no_dup_start", 72'(job_active), 72'(0));
        check("start_expected", 72'(q.size() != 0), 72'(1));
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          check("win", cur_win(), mon_e.win);
          check("win_row", 72'(bus.o_win_row), 72'(mon_e.row));
          check("win_col", 72'(bus.o_win_col), 72'(mon_e.col));
          check("start_ready", 72'(bus.o_pix_ready), 72'(0));
          held       = mon_e;
          job_active = 1;
          seen_done  = 0;
        end
      end else if (job_active) begin
        if (seen_done && !done_q) begin
          check("ready_return", 72'(bus.o_pix_ready), 72'(1));
          check("frame_done", 72'(bus.o_frame_done), 72'(held.last));
          job_active = 0;
        end else begin
          check("stall_ready", 72'(bus.o_pix_ready), 72'(0));
          check("hold_win", cur_win(), held.win);
          check("hold_row", 72'(bus.o_win_row), 72'(held.row));
          check("hold_col", 72'(bus.o_win_col), 72'(held.col));
          if (done_q) seen_done = 1;
        end
      end
    end
  end

  // Detector stand-in: done rises d cycles after start and stays high for l cycles
  initial begin
    int d, l;
    bus.i_gradient_done = 1'b0;
    forever begin
      @(negedge clk);
      if (det_en && !rst && bus.o_gradient_start) begin
        d = int'($urandom_range(dmax, dmin));
        l = int'($urandom_range(lmax, lmin));
        repeat (d) @(negedge clk);
        bus.i_gradient_done = 1'b1;
        repeat (l) @(negedge clk);
        bus.i_gradient_done = 1'b0;
      end
    end
  end

  task automatic send_pixel(input logic [7:0] p, input bit gappy);
    int  n = 0;
    bit  gap_done = 0;
    forever begin
      @(negedge clk);
      if (gappy && !gap_done) begin
        bus.i_pix_valid = 1'b0;
        gap_done = 1;
      end else begin
        bus.i_pix_valid = 1'b1;
        bus.i_pix_data  = p;
        if (bus.o_pix_ready) begin
          model_accept(p);
          return;
        end
      end
      n++;
      if (n > 500) give_up("send_pixel");
    end
  endtask

  task automatic send_frame(input int npix, input int base, input bit rnd, input bit gappy);
    for (int i = 0; i < npix; i++) begin
      send_pixel(rnd ? 8'($urandom) : 8'(base + i), gappy);
    end
    @(negedge clk);
    bus.i_pix_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!(q.size() == 0 && !job_active && bus.o_pix_ready)) begin
      @(negedge clk);
      n++;
      if (n > 1000) give_up("drain");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_win", cur_win(), 72'(0));
    check("rst_start", 72'(bus.o_gradient_start), 72'(0));
    check("rst_row", 72'(bus.o_win_row), 72'(0));
    check("rst_col", 72'(bus.o_win_col), 72'(0));
    check("rst_frame_done", 72'(bus.o_frame_done), 72'(0));
    check("rst_ready", 72'(bus.o_pix_ready), 72'(1));
  endtask

  task automatic set_det(input int d0, input int d1, input int l0, input int l1);
    dmin = d0; dmax = d1; lmin = l0; lmax = l1;
  endtask

  initial begin
    bus.i_pix_valid = 1'b0;
    bus.i_pix_data  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs();
    mon_en = 1;

    // Sequential 0..15 frame, done 3 cycles after start for 2 cycles
    set_det(3, 3, 2, 2);
    send_frame(16, 0, 0, 0);
    drain();
    check("frameA_starts", 72'(n_start), 72'(4));
    check("frameA_fdone", 72'(n_fd), 72'(1));

    // Back-pressure: long detector latency
    set_det(20, 20, 2, 2);
    send_frame(16, 0, 1, 0);
    drain();

    // Long done pulse
    set_det(1, 2, 5, 5);
    send_frame(16, 0, 1, 0);
    drain();

    // Gappy valid on the sequential frame
    set_det(3, 3, 2, 2);
    send_frame(16, 0, 0, 1);
    drain();

    // Reset while the detector job is in flight, then a stray done
    det_en = 0;
    for (int i = 0; i < 11; i++) send_pixel(8'(i), 0);
    @(negedge clk);
    bus.i_pix_valid = 1'b0;
    @(negedge clk);
    mon_en = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs();
    q.delete();
    job_active = 0;
    mrow = 0;
    mcol = 0;
    bus.i_gradient_done = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("stray_no_start", 72'(bus.o_gradient_start), 72'(0));
    end
    bus.i_gradient_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("stray_no_start", 72'(bus.o_gradient_start), 72'(0));
      check("stray_ready", 72'(bus.o_pix_ready), 72'(1));
    end
    mon_en = 1;
    det_en = 1;
    send_frame(16, 0, 0, 0);
    drain();

    // Back-to-back frames, 32 sequential pixels
    set_det(1, 4, 1, 3);
    send_frame(32, 0, 0, 0);
    drain();

    // Random frames with gaps and random detector timing
    set_det(1, 8, 1, 4);
    repeat (3) send_frame(16, 0, 1, 1);
    drain();

    check("total_starts", 72'(n_start), 72'(n_exp_start));
    check("total_frame_done", 72'(n_fd), 72'(n_exp_fd));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_fetch.md
Name: window_fetch

Overview:
- Upstream feeder for edge_detection.
- Accepts a raster-order 8-bit pixel stream through a valid/ready handshake and keeps two line buffers plus a 3x3 window register.
- For every interior pixel position it presents P0..P8 with a one-cycle start pulse.
- Holds the window stable, and stalls the stream, until the detector signals completion.

Parameters:
IMG_WIDTH, 16, pixels per line (>=3)
IMG_HEIGHT, 16, lines per frame (>=3)
COL_W, $clog2(IMG_WIDTH), column counter width (derived)
ROW_W, $clog2(IMG_HEIGHT), row counter width (derived)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_pix_valid  in  1  pixel on i_pix_data is valid
i_pix_data  in  8  pixel, raster order, row 0 col 0 first
o_pix_ready  out  1  block accepts a pixel this cycle
o_P0..o_P8  out  8 each  window; P0..P2 = row r-2, P3..P5 = row r-1, P6..P8 = row r; left to right within each row
o_gradient_start  out  1  one-cycle pulse, feeds detector start
i_gradient_done  in  1  detector data-ready (asserted >=1 cycle per job)
o_win_row  out  ROW_W  centre row (r-1) of the presented window
o_win_col  out  COL_W  centre col (c-1) of the presented window
o_frame_done  out  1  one-cycle pulse after the last window's handshake completes

Behaviour:
- Reset (rst high at a clk edge): the following all go to 0.
  - Outputs: P0..P8, o_gradient_start, o_win_row/col, o_frame_done.
  - Counters: col, row.
  - Line buffers.
  - FSM goes to ACCEPT. o_pix_ready is then 1 (combinational from state).
  - Reset wins over every other event. A handshake in flight is abandoned, and a later i_gradient_done is ignored until the next START.
- Accept: a pixel is taken when i_pix_valid && o_pix_ready. On that edge, at column c:
  - Window shifts left: P0<=P1, P1<=P2, P2<=lb1[c]; P3<=P4, P4<=P5, P5<=lb0[c]; P6<=P7, P7<=P8, P8<=pix.
  - Line buffers: lb1[c]<=lb0[c], lb0[c]<=pix. Read-before-write at the same index.
  - col increments. Wrap at IMG_WIDTH-1 to 0 and increment row. Wrap row at IMG_HEIGHT-1 to 0.
- States:
  - ACCEPT: o_pix_ready=1. On accept, if the accepted pixel has row>=2 && col>=2: capture o_win_row=row-1 and o_win_col=col-1, remember whether it was the last pixel of the frame, and go to START. Otherwise stay in ACCEPT.
  - START: o_gradient_start=1 for exactly one cycle; o_pix_ready=0; next state WAIT_DONE.
  - WAIT_DONE: o_pix_ready=0; go to WAIT_CLEAR when i_gradient_done=1.
  - WAIT_CLEAR: o_pix_ready=0; go to ACCEPT when i_gradient_done=0. If the frame-last flag is set, pulse o_frame_done on that transition and clear the flag.
- Why WAIT_CLEAR exists: the detector holds its ready output for two cycles. Waiting for deassertion guarantees one start per window and no double-counting.
- Latency:
  - Pixel accepted to o_gradient_start: 1 cycle.
  - Minimum period between accepts around a window: 4 cycles plus detector time.
  - Non-window pixels (rows 0-1, cols 0-1): one per cycle, no start pulse.
- Window stability: P0..P8, o_win_row and o_win_col are constant from START until return to ACCEPT. The detector may sample them at any cycle of its job.
- i_gradient_done asserted while in ACCEPT or START is ignored.
- i_pix_valid low in ACCEPT: no state change.
- Window count per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2). The next frame starts immediately with row 0 fill, and line contents are overwritten before use.
- No arithmetic beyond the counters. Pixels are unsigned 8-bit and pass through unchanged.

Decomposition:
- Package edge_pkg holds:
  - fetch_state_t enum {ACCEPT, START, WAIT_DONE, WAIT_CLEAR}.
  - PIX_W=8.
  - Default IMG_WIDTH/IMG_HEIGHT constants.
- One sub-module, line_buffer: parameterised depth, 8-bit, registered array, synchronous reset, combinational read at index, write on enable. Instantiate twice (lb0, lb1).

Test Plan:
- IMG_WIDTH=IMG_HEIGHT=4, pixels 0..15, done returned 3 cycles after start for 2 cycles:
  - First start follows pixel 10 with P0..P8 = 0,1,2,4,5,6,8,9,10 and win=(1,1).
  - Second start follows pixel 11 with P0..P8 = 1,2,3,5,6,7,9,10,11 and win=(1,2).
  - Exactly 4 starts in total; o_frame_done pulses once after the 4th done falls.
- Back-pressure: hold i_gradient_done low for 20 cycles after a start. o_pix_ready stays 0, P0..P8 are unchanged every cycle, and no second start occurs.
- Long done: hold i_gradient_done high for 5 cycles. There is exactly one start, and o_pix_ready returns 1 the cycle after done falls.
- Gappy valid: i_pix_valid toggling 1,0,1,0 over the 4x4 frame gives identical windows and order as the first case.
- Reset mid-job: assert rst in WAIT_DONE. The next cycle shows all outputs 0 and o_pix_ready=1; a stray done pulse produces no start. Re-sending the frame reproduces the first case.
- Back-to-back frames: send 32 pixels. 8 starts occur, the first window of frame 2 equals the first case's first window (value-shifted by 16), and o_frame_done pulses twice.
